// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared constants, types and helpers for the AES-128 key schedule.
//   AES_NR_128 : round count for AES-128
//   RCON_INIT  : first round constant
//   state_e    : key-expansion FSM states
//   xtime      : GF(2^8) multiply-by-x, used to advance the round constant
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int unsigned AES_NR_128 = 10;
    localparam logic [7:0]  RCON_INIT  = 8'h01;

    typedef enum logic {
        IDLE,
        EXPAND
    } state_e;

    // Multiply by x modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
// Combinational AES forward S-box (SubBytes on one byte).
//   sbox_i : input byte
//   sbox_o : substituted byte
// ---------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] sbox_i,
    output logic [7:0] sbox_o
);

    // Entry for byte x lives at bits [(255-x)*8 +: 8], i.e. row 0 is the MSBs.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // (255 - x) * 8 == {~x, 3'b000}
    assign sbox_o = SBOX_TABLE[{~sbox_i, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expand_iter.sv
// ---------------------------------------------------------------------------
// aes_key_expand_iter
// Iterative AES-128 key schedule: one round key per clock, all round keys
// held in registers and presented flat to the unrolled encrypt pipeline.
//   clk             : clock
//   rst_n           : asynchronous active-low reset
//   key_load        : one-cycle request to expand key_in (honoured in IDLE only)
//   key_in          : 128-bit cipher key, w0 = key_in[127:96]
//   busy            : expansion in progress, key_load ignored
//   keys_valid      : round_keys_flat complete and stable
//   round_keys_flat : rk[k] = round_keys_flat[k*128 +: 128], k = 0..NR
// Latency: key_load sampled at edge T, rk[i] written at edge T+i,
// keys_valid high after edge T+NR.
// ---------------------------------------------------------------------------
module aes_key_expand_iter
    import aes_pkg::*;
#(
    parameter int unsigned NR = AES_NR_128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  key_load,
    input  logic [127:0]          key_in,
    output logic                  busy,
    output logic                  keys_valid,
    output logic [(NR+1)*128-1:0] round_keys_flat
);

    if (NR != AES_NR_128) begin : g_bad_nr
        $error("aes_key_expand_iter: NR must be 10 (AES-128)");
    end

    localparam int unsigned CNT_W = 4;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         rcon_q, rcon_d;
    logic               keys_valid_q, keys_valid_d;
    logic [127:0]       rk_q [0:NR];

    // Round-key write port, driven by the FSM.
    logic               rk_we;
    logic [CNT_W-1:0]   rk_widx;
    logic [127:0]       rk_wdata;

    // -----------------------------------------------------------------------
    // Round step: rk[cnt] derived from rk[cnt-1]
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0]   prev_idx;
    logic [127:0]       prev_key;
    logic [31:0]        w0, w1, w2, w3;
    logic [31:0]        rot_w3, sub_w3, t_word;
    logic [31:0]        n0, n1, n2, n3;
    logic [127:0]       next_key;

    // cnt is 0 only before the first load; clamp so the read stays in range.
    assign prev_idx = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
    assign prev_key = rk_q[prev_idx];

    assign {w0, w1, w2, w3} = prev_key;
    assign rot_w3 = {w3[23:0], w3[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .sbox_i (rot_w3[b*8 +: 8]),
            .sbox_o (sub_w3[b*8 +: 8])
        );
    end

    assign t_word   = sub_w3 ^ {rcon_q, 24'h0};
    assign n0       = w0 ^ t_word;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    // -----------------------------------------------------------------------
    // FSM: next state and write-port control
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch to hold the value.
        state_d      = state_q;
        cnt_d        = cnt_q;
        rcon_d       = rcon_q;
        keys_valid_d = keys_valid_q;
        rk_we        = 1'b0;
        rk_widx      = cnt_q;
        rk_wdata     = next_key;

        unique case (state_q)
            IDLE: begin
                if (key_load) begin
                    rk_we        = 1'b1;
                    rk_widx      = '0;
                    rk_wdata     = key_in;
                    cnt_d        = CNT_W'(1);
                    rcon_d       = RCON_INIT;
                    keys_valid_d = 1'b0;
                    state_d      = EXPAND;
                end
            end
            EXPAND: begin
                rk_we  = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                rcon_d = xtime(rcon_q);
                if (cnt_q == CNT_W'(NR)) begin
                    keys_valid_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rcon_q       <= RCON_INIT;
            keys_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rcon_q       <= rcon_d;
            keys_valid_q <= keys_valid_d;
        end
    end

    // -----------------------------------------------------------------------
    // Round-key storage
    // -----------------------------------------------------------------------
    // NOTE: this array is deliberately flop-based and reset, because a reset
    // must clear every key on the output bus; a RAM-style array would not be.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= NR; k++) begin
                rk_q[k] <= '0;
            end
        end else if (rk_we) begin
            rk_q[rk_widx] <= rk_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: registers only
    // -----------------------------------------------------------------------
    assign busy       = (state_q == EXPAND);
    assign keys_valid = keys_valid_q;

    for (genvar k = 0; k <= NR; k++) begin : g_flat
        assign round_keys_flat[k*128 +: 128] = rk_q[k];
    end

endmodule

// File: tb/tb_aes_key_expand_iter.sv
// ---------------------------------------------------------------------------
// tb_aes_key_expand_iter
// Scoreboard bench for aes_key_expand_iter. The expected schedule for each
// accepted load comes from an independent word-oriented key-expansion model
// whose S-box is computed from the GF(2^8) inverse and affine transform.
// ---------------------------------------------------------------------------
module tb_aes_key_expand_iter;

    localparam int NR     = 10;
    localparam int FLAT_W = (NR+1)*128;

    logic              clk;
    logic              rst_n;
    logic              key_load;
    logic [127:0]      key_in;
    logic              busy;
    logic              keys_valid;
    logic [FLAT_W-1:0] round_keys_flat;

    aes_key_expand_iter #(.NR(NR)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .key_load        (key_load),
        .key_in          (key_in),
        .busy            (busy),
        .keys_valid      (keys_valid),
        .round_keys_flat (round_keys_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [FLAT_W-1:0] sb [$];
    logic [7:0]        sbox_tb [256];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_tb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                         ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tb[w[31:24]], sbox_tb[w[23:16]], sbox_tb[w[15:8]], sbox_tb[w[7:0]]};
    endfunction

    function automatic logic [FLAT_W-1:0] model_expand(input logic [127:0] key);
        logic [31:0]       w [44];
        logic [31:0]       temp;
        logic [7:0]        rc;
        logic [FLAT_W-1:0] flat;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc   = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int k = 0; k <= NR; k++) flat[k*128 +: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        return flat;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [FLAT_W-1:0] flat);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] st;
        st = pt ^ flat[127:0];
        for (int r = 1; r <= NR; r++) begin
            for (int j = 0; j < 16; j++) s[j] = sbox_tb[st[127 - 8*j -: 8]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[row + 4*c] = s[row + 4*((c + row) % 4)];
            if (r != NR) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int j = 0; j < 16; j++) st[127 - 8*j -: 8] = t[j];
            st = st ^ flat[r*128 +: 128];
        end
        return st;
    endfunction

    // ---------------- scoreboard monitor ----------------
    logic kv_prev = 1'b0;
    initial begin
        logic [FLAT_W-1:0] exp_flat;
        forever begin
            @(negedge clk);
            if (keys_valid && !kv_prev) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_valid", 128'd1, 128'd0);
                end else begin
                    exp_flat = sb.pop_front();
                    for (int k = 0; k <= NR; k++)
                        check($sformatf("sb_rk%0d", k), round_keys_flat[k*128 +: 128], exp_flat[k*128 +: 128]);
                end
            end
            kv_prev = keys_valid;
        end
    end

    // ---------------- driver helpers ----------------
    // Called at a negedge: drives key_load for the next edge (T).
    task automatic load_key(input logic [127:0] key, input logic push);
        key_in   = key;
        key_load = 1'b1;
        if (push) sb.push_back(model_expand(key));
        @(posedge clk);
        #1 key_load = 1'b0;
    endtask

    // Follows edge T to completion; optionally re-pulses key_load at edge T+4.
    task automatic wait_done(input string tag, input logic inject, input logic [127:0] inj_key);
        int lat = 0;
        int busy_cycles = 0;
        @(negedge clk);
        if (busy) busy_cycles++;
        check({tag, "_kv_low_after_T"}, 128'(keys_valid), 128'd0);
        for (int n = 1; n <= 20; n++) begin
            if (inject && n == 4) begin
                key_in   = inj_key;
                key_load = 1'b1;
            end
            @(posedge clk);
            #1 key_load = 1'b0;
            @(negedge clk);
            if (busy) busy_cycles++;
            if (keys_valid) begin
                lat = n;
                break;
            end
        end
        check({tag, "_latency"}, 128'(lat), 128'd10);
        check({tag, "_busy_cycles"}, 128'(busy_cycles), 128'd10);
        check({tag, "_busy_low_at_valid"}, 128'(busy), 128'd0);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus ----------------
    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] SEQ_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    initial begin
        logic [127:0] k;
        rst_n    = 1'b0;
        key_load = 1'b0;
        key_in   = '0;
        build_sbox();

        // Reset state
        #3;
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_keys_valid", 128'(keys_valid), 128'd0);
        check("rst_flat_nonzero", 128'(|round_keys_flat), 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 key plus cipher cross-check
        load_key(FIPS_KEY, 1'b1);
        wait_done("fips", 1'b0, '0);
        check("fips_rk0", round_keys_flat[0 +: 128], FIPS_KEY);
        check("fips_rk1", round_keys_flat[128 +: 128], 128'ha0fafe1788542cb123a339392a6c7605);
        check("fips_rk10", round_keys_flat[10*128 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("fips_cipher", encrypt(FIPS_PT, round_keys_flat), 128'h3925841d02dc09fbdc118597196a0b32);
        repeat (3) @(negedge clk);
        check("hold_rk10", round_keys_flat[10*128 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("hold_keys_valid", 128'(keys_valid), 128'd1);

        // Sequential key
        load_key(SEQ_KEY, 1'b1);
        wait_done("seq", 1'b0, '0);
        check("seq_rk0", round_keys_flat[0 +: 128], SEQ_KEY);
        check("seq_rk10", round_keys_flat[10*128 +: 128], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        @(negedge clk);

        // Reload while busy must be ignored
        load_key(FIPS_KEY, 1'b1);
        wait_done("ignore", 1'b1, rand128());
        check("ignore_rk10", round_keys_flat[10*128 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        repeat (2) @(negedge clk);
        check("ignore_no_restart", 128'(busy), 128'd0);

        // Back-to-back: reload the cycle after keys_valid rises
        k = rand128();
        load_key(k, 1'b1);
        wait_done("b2b_a", 1'b0, '0);
        load_key(SEQ_KEY, 1'b1);
        wait_done("b2b_b", 1'b0, '0);
        check("b2b_rk10", round_keys_flat[10*128 +: 128], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        @(negedge clk);

        // Reset mid-expansion
        load_key(rand128(), 1'b1);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_keys_valid", 128'(keys_valid), 128'd0);
        check("midrst_flat_nonzero", 128'(|round_keys_flat), 128'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_key(FIPS_KEY, 1'b1);
        wait_done("post_rst", 1'b0, '0);
        check("post_rst_rk10", round_keys_flat[10*128 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // A few random keys
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            load_key(rand128(), 1'b1);
            wait_done("rand", 1'b0, '0);
        end

        repeat (2) @(negedge clk);
        check("sb_leftover", 128'(sb.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
